// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage-register state encoding and
// control-bundle field positions used by every stage boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        SKIDDED = 2'd2
    } state_e;

    // A zero control bundle is a bubble: no write-back, no memory access.
    localparam logic CTRL_NOP = 1'b0;

    // WB pair.
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_TO_REG = 2;

    // MEM pair.
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events; holds at all-ones
// and is cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Step by one on each event unless already at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Falling-edge update to match the pipeline latch timing.
    always_ff @(negedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional
// one-entry skid buffer, flush-to-bubble and a stall-cycle counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              ready_q, ready_d;
    logic              in_fire;
    logic              out_fire;

    assign valid_o  = (state_q != EMPTY);
    assign out_fire = valid_o & out_ready_i & ~stall_i;
    assign in_fire  = valid_i & ready_o;
    assign ready_o  = (SKID != 0) ? ready_q : (~valid_o | out_fire);
    assign data_o   = main_data_q;
    assign ctrl_o   = valid_o ? main_ctrl_q : {CTRL_W{CTRL_NOP}};

    // Next-state: flush first, then the main/skid occupancy transitions.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush_i) begin
            state_d     = EMPTY;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_d = data_i;
                        main_ctrl_d = ctrl_i;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_data_d = data_i;
                        main_ctrl_d = ctrl_i;
                    end else if (in_fire && (SKID != 0)) begin
                        skid_data_d = data_i;
                        skid_ctrl_d = ctrl_i;
                        state_d     = SKIDDED;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                SKIDDED: begin
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        ready_d = (state_d != SKIDDED);
    end

    // State and entry registers, updated on the falling edge.
    always_ff @(negedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            ready_q     <= ready_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (valid_o & ~out_fire),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with an in-order scoreboard
// covering the skid, no-skid and narrow-counter configurations.
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  c;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [3:0]  ctrl_i = '0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        out_ready_i = 1'b0;

    logic        d_valid, d_ready;
    logic [31:0] d_data;
    logic [3:0]  d_ctrl;
    logic [15:0] d_cnt;

    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_ctrl;
    logic [2:0]  s_cnt;

    logic        n_valid_i = 1'b0;
    logic [31:0] n_data_i = '0;
    logic [3:0]  n_ctrl_i = '0;
    logic        n_out_ready_i = 1'b0;
    logic        n_valid, n_ready;
    logic [31:0] n_data;
    logic [3:0]  n_ctrl;
    logic [15:0] n_cnt;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    ent_t q[$];
    ent_t nq[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(d_ready),
        .data_i(data_i), .ctrl_i(ctrl_i), .stall_i(stall_i),
        .flush_i(flush_i), .valid_o(d_valid), .out_ready_i(out_ready_i),
        .data_o(d_data), .ctrl_o(d_ctrl), .stall_cnt_o(d_cnt)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(3)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(s_ready),
        .data_i(data_i), .ctrl_i(ctrl_i), .stall_i(stall_i),
        .flush_i(flush_i), .valid_o(s_valid), .out_ready_i(out_ready_i),
        .data_o(s_data), .ctrl_o(s_ctrl), .stall_cnt_o(s_cnt)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .SKID(0), .CNT_W(16)) u_ns (
        .clk_i(clk), .rst_i(rst_n), .valid_i(n_valid_i), .ready_o(n_ready),
        .data_i(n_data_i), .ctrl_i(n_ctrl_i), .stall_i(1'b0),
        .flush_i(1'b0), .valid_o(n_valid), .out_ready_i(n_out_ready_i),
        .data_o(n_data), .ctrl_o(n_ctrl), .stall_cnt_o(n_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, inout ent_t qq[$],
                           input logic [31:0] od, input logic [3:0] oc);
        ent_t e;
        if (qq.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s_empty observed=%0h expected=none", tag, od);
        end else begin
            e = qq.pop_front();
            chk({tag, "_data"}, 64'(od), 64'(e.d));
            chk({tag, "_ctrl"}, 64'(oc), 64'(e.c));
        end
    endtask

    // One clock: settle on the rising edge, score, then let the
    // falling edge update the DUTs and step 1 unit past it.
    task automatic cyc();
        @(posedge clk);
        if (flush_i) begin
            q.delete();
        end else begin
            if (d_valid && out_ready_i && !stall_i)
                pop_chk("sb", q, d_data, d_ctrl);
            if (valid_i && d_ready)
                q.push_back('{d: data_i, c: ctrl_i});
        end
        if (n_valid && n_out_ready_i)
            pop_chk("nsb", nq, n_data, n_ctrl);
        if (n_valid_i && n_ready)
            nq.push_back('{d: n_data_i, c: n_ctrl_i});
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        q.delete();
        nq.delete();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(d_valid), 64'd0);
        chk("rst_ready", 64'(d_ready), 64'd1);
        chk("rst_data", 64'(d_data), 64'd0);
        chk("rst_ctrl", 64'(d_ctrl), 64'd0);
        chk("rst_cnt", 64'(d_cnt), 64'd0);
        chk("rst_ns_ready", 64'(n_ready), 64'd1);
        #1 rst_n = 1'b1;

        // First transfer, one falling edge of latency.
        valid_i = 1'b1;
        data_i = 32'h0000_00AA;
        ctrl_i = 4'b1010;
        out_ready_i = 1'b1;
        cyc();
        chk("lat_valid", 64'(d_valid), 64'd1);
        chk("lat_data", 64'(d_data), 64'h0000_00AA);
        chk("lat_ctrl", 64'(d_ctrl), 64'b1010);

        // Back-to-back stream.
        for (int i = 1; i <= 5; i++) begin
            data_i = 32'(i);
            ctrl_i = 4'(i);
            cyc();
            chk("b2b_data", 64'(d_data), 64'(i));
            chk("b2b_ready", 64'(d_ready), 64'd1);
        end
        valid_i = 1'b0;
        cyc();
        chk("drain_valid", 64'(d_valid), 64'd0);
        chk("drain_ctrl", 64'(d_ctrl), 64'd0);

        // Skid capture while downstream is blocked.
        out_ready_i = 1'b0;
        valid_i = 1'b1;
        data_i = 32'h11;
        ctrl_i = 4'b1000;
        cyc();
        data_i = 32'h22;
        ctrl_i = 4'b0100;
        cyc();
        valid_i = 1'b0;
        chk("skid_ready", 64'(d_ready), 64'd0);
        chk("skid_data", 64'(d_data), 64'h11);
        chk("skid_valid", 64'(d_valid), 64'd1);
        out_ready_i = 1'b1;
        cyc();
        chk("skid_rel1", 64'(d_data), 64'h22);
        chk("skid_rel_ready", 64'(d_ready), 64'd1);
        cyc();
        chk("skid_rel2", 64'(d_valid), 64'd0);

        // Stall counting and saturation.
        pulse_reset();
        valid_i = 1'b1;
        data_i = 32'h44;
        ctrl_i = 4'b0010;
        cyc();
        valid_i = 1'b0;
        stall_i = 1'b1;
        repeat (5) cyc();
        chk("stall_data", 64'(d_data), 64'h44);
        chk("stall_cnt5", 64'(d_cnt), 64'd5);
        chk("stall_sat5", 64'(s_cnt), 64'd5);
        repeat (5) cyc();
        chk("stall_cnt10", 64'(d_cnt), 64'd10);
        chk("stall_sat7", 64'(s_cnt), 64'd7);

        // Asynchronous reset between edges while full.
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_valid", 64'(d_valid), 64'd0);
        chk("arst_cnt", 64'(d_cnt), 64'd0);
        chk("arst_ready", 64'(d_ready), 64'd1);
        rst_n = 1'b1;
        stall_i = 1'b0;
        cyc();
        chk("arst_nopulse", 64'(d_valid), 64'd0);

        // Flush while skidded, with a new input offered.
        out_ready_i = 1'b0;
        valid_i = 1'b1;
        data_i = 32'h55;
        ctrl_i = 4'b1111;
        cyc();
        data_i = 32'h66;
        cyc();
        chk("fl_pre_ready", 64'(d_ready), 64'd0);
        data_i = 32'h77;
        flush_i = 1'b1;
        cyc();
        chk("fl_valid", 64'(d_valid), 64'd0);
        chk("fl_ctrl", 64'(d_ctrl), 64'd0);
        chk("fl_ready", 64'(d_ready), 64'd1);
        flush_i = 1'b0;
        valid_i = 1'b0;
        out_ready_i = 1'b1;
        cyc();
        chk("fl_gone", 64'(d_valid), 64'd0);

        // Flush and stall together while full; input dropped.
        valid_i = 1'b1;
        data_i = 32'h88;
        ctrl_i = 4'b0001;
        cyc();
        chk("fs_pre", 64'(d_valid), 64'd1);
        data_i = 32'h99;
        flush_i = 1'b1;
        stall_i = 1'b1;
        cyc();
        chk("fs_valid", 64'(d_valid), 64'd0);
        chk("fs_ctrl", 64'(d_ctrl), 64'd0);
        flush_i = 1'b0;
        stall_i = 1'b0;
        valid_i = 1'b0;
        cyc();
        chk("fs_dropped", 64'(d_valid), 64'd0);

        // No-skid variant: combinational ready.
        n_valid_i = 1'b1;
        n_data_i = 32'h32;
        n_ctrl_i = 4'b0110;
        n_out_ready_i = 1'b0;
        cyc();
        n_data_i = 32'h33;
        n_ctrl_i = 4'b0011;
        #1;
        chk("ns_ready_lo", 64'(n_ready), 64'd0);
        chk("ns_hold", 64'(n_data), 64'h32);
        n_out_ready_i = 1'b1;
        #1;
        chk("ns_ready_hi", 64'(n_ready), 64'd1);
        cyc();
        chk("ns_nobubble_v", 64'(n_valid), 64'd1);
        chk("ns_nobubble_d", 64'(n_data), 64'h33);
        n_valid_i = 1'b0;
        cyc();
        chk("ns_drain", 64'(n_valid), 64'd0);

        chk("sb_drain", 64'(q.size()), 64'd0);
        chk("nsb_drain", 64'(nq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register, successor to the fixed-width inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W payload and a CTRL_W control bundle (WB/MEM/EX bits) between stages.
- Adds a valid/ready handshake, an optional one-entry skid buffer, synchronous flush (bubble insertion), and a saturating stall-cycle counter.
- Instantiated once per stage boundary in the pipelined CPU; the legacy stall input is kept.

Parameters:
- DATA_W, 32: payload width (ALU result, RT value, register index, packed as the instantiating stage needs).
- CTRL_W, 4: control bundle width; zero means no-op or bubble.
- SKID, 1: 1 = two-entry (main + skid) registered-ready; 0 = single register, combinational ready.
- CNT_W, 16: stall counter width.

Ports:
- clk_i, input, 1: stage clock; all state updates on the falling edge of clk_i (pipeline latch convention).
- rst_i, input, 1: asynchronous, active-low reset.
- valid_i, input, 1: upstream entry valid.
- ready_o, output, 1: stage can accept this cycle.
- data_i, input, DATA_W: upstream payload.
- ctrl_i, input, CTRL_W: upstream control bundle.
- stall_i, input, 1: hazard-unit hold; acts as downstream not-ready.
- flush_i, input, 1: discard all held entries (branch taken, exception).
- valid_o, output, 1: output entry valid.
- out_ready_i, input, 1: downstream accepts.
- data_o, output, DATA_W: held payload.
- ctrl_o, output, CTRL_W: held control; forced to 0 whenever valid_o=0.
- stall_cnt_o, output, CNT_W: cycles with valid_o=1 and no output transfer.

Behaviour:
- Definitions: in_fire = valid_i & ready_o; out_fire = valid_o & out_ready_i & ~stall_i.
- Reset (rst_i=0, asynchronous): state EMPTY, valid_o=0, ready_o=1, data_o=0, ctrl_o=0, skid regs=0, stall_cnt_o=0.
- Latency: 1 falling edge from in_fire to valid_o/data_o update. Throughput 1 per cycle when not stalled.
- State machine, SKID=1 (states EMPTY, FULL, SKIDDED):
  - EMPTY, in_fire: load main -> FULL.
  - FULL:
    - in_fire & out_fire: main <= input, stay FULL.
    - in_fire & ~out_fire: skid <= input -> SKIDDED.
    - ~in_fire & out_fire: -> EMPTY.
  - SKIDDED: ready_o=0. out_fire: main <= skid -> FULL. No input is accepted in this state.
  - ready_o is registered: 1 in EMPTY/FULL, 0 in SKIDDED.
- SKID=0: states EMPTY and FULL only; ready_o = ~valid_o | out_fire (combinational). Main loads on in_fire.
- Flush (synchronous, highest priority): next state EMPTY, valid_o=0, ctrl_o=0, skid entry discarded, ready_o=1.
  - An in_fire in the same cycle is dropped.
  - data_o holds its value (don't-care).
- flush_i together with stall_i: flush wins.
- stall_i with valid_o=0: no effect. An input may still be accepted.
- Ordering: entries leave in acceptance order; skid never overtakes main.
- Counter: increments when valid_o & ~out_fire; saturates at 2^CNT_W-1; unaffected by flush; cleared only by reset.
- Reset mid-transfer: all entries lost, no output pulse.

Decomposition:
- Shared package pipe_pkg: state encoding constants (EMPTY=2'd0, FULL=2'd1, SKIDDED=2'd2), CTRL_NOP = 0, bit positions of the WB/MEM fields in the ctrl bundle (MemRead=1, MemWrite=0 for the MEM pair).
- One natural sub-module: sat_counter (CNT_W, inc, saturating), reusable by other perf counters.

Test Plan:
- Reset, then valid_i=1, data_i=32'h0000_00AA, ctrl_i=4'b1010, out_ready_i=1 -> after 1 falling edge: valid_o=1, data_o=32'h0000_00AA, ctrl_o=4'b1010. Back-to-back 0x01..0x05 emerge in order, one per cycle.
- SKID=1, FULL with 0x11, out_ready_i=0, input 0x22 -> SKIDDED, ready_o=0, data_o=0x11. Release out_ready_i -> 0x11 then 0x22 on consecutive edges.
- stall_i=1 for 5 cycles with valid_o=1 -> data_o held, stall_cnt_o=5. With CNT_W=3 and 10 stall cycles -> stall_cnt_o=7 (saturated).
- SKIDDED state, flush_i=1 with valid_i=1 -> next edge valid_o=0, ctrl_o=0, ready_o=1, both entries and the new input gone.
- flush_i and stall_i asserted together -> flush wins: valid_o=0.
- rst_i dropped asynchronously between clock edges while FULL -> valid_o=0 immediately; stall_cnt_o=0.
- SKID=0: out_ready_i=0 with valid_o=1 -> ready_o=0 in the same cycle. out_ready_i=1 -> ready_o=1 combinationally, 0x33 replaces 0x32 with no bubble.
